// File: rtl/uart_fifo.sv
// UART with byte FIFOs on both directions, register-mapped bus interface.
// Frame: start, 8 data LSB first, optional parity, 1 or 2 stop bits.

module uart_fifo_buf #(
  parameter int AW = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  rdata,
  output logic [AW:0] count,
  output logic        full,
  output logic        empty
);
  logic [7:0]  mem [2**AW];
  logic [AW:0] wp, rp;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + (AW+1)'(1);
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end

  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= wdata;

  // extra pointer bit distinguishes full from empty at equal indices
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign count = wp - rp;
  assign rdata = mem[rp[AW-1:0]];
endmodule

module uart_fifo #(
  parameter int WIDTH     = 32,
  parameter int RX_AW     = 4,
  parameter int TX_AW     = 4,
  parameter int CPB_RESET = 216
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             cs,
  input  logic             wen,
  input  logic [3:0]       addr,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             RxD,
  output logic             TxD,
  output logic             irq
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [4:0]  ctrl;
  logic [15:0] cpb;
  logic [2:0]  ien;
  logic [3:0]  rx_err;   // {BREAK, RX_OVR, PERR, FERR}
  logic        tx_ovr;

  logic wr, rd_dr, rd_prev;
  assign wr    = cs & wen;
  assign rd_dr = cs & ~wen & (addr == 4'd0);

  logic [15:0] cpb_eff, half;
  assign cpb_eff = (cpb < 16'd4) ? 16'd4 : cpb;
  assign half    = {1'b0, cpb_eff[15:1]};

  logic unused_din;
  assign unused_din = ^din;

  // FIFOs
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]       tx_rdata;
  logic [TX_AW:0]   tx_count;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]       rx_rdata, rx_sh;
  logic [RX_AW:0]   rx_count;

  assign tx_push = wr & (addr == 4'd0);
  assign rx_pop  = rd_dr & ~rd_prev;

  uart_fifo_buf #(.AW(TX_AW)) u_txq (
    .clk(clk), .resetn(resetn), .push(tx_push), .wdata(din[7:0]), .pop(tx_pop),
    .rdata(tx_rdata), .count(tx_count), .full(tx_full), .empty(tx_empty));

  uart_fifo_buf #(.AW(RX_AW)) u_rxq (
    .clk(clk), .resetn(resetn), .push(rx_push), .wdata(rx_sh), .pop(rx_pop),
    .rdata(rx_rdata), .count(rx_count), .full(rx_full), .empty(rx_empty));

  // Transmitter
  state_t      tx_state, tx_next;
  logic [16:0] tx_cnt, tx_len;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_sh;
  logic        tx_par, tx_end, tc;

  assign tx_len = (tx_state == S_STOP && ctrl[4]) ? {cpb_eff, 1'b0} : {1'b0, cpb_eff};
  assign tx_end = (tx_cnt == tx_len - 17'd1);
  assign tc     = tx_empty && (tx_state == S_IDLE);

  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      S_IDLE:   if (!tx_empty && ctrl[1]) begin tx_next = S_START; tx_pop = 1'b1; end
      S_START:  if (tx_end) tx_next = S_DATA;
      S_DATA:   if (tx_end && tx_bit == 3'd7) tx_next = ctrl[2] ? S_PARITY : S_STOP;
      S_PARITY: if (tx_end) tx_next = S_STOP;
      S_STOP:   if (tx_end) tx_next = S_IDLE;
      default:  tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_state == S_IDLE || tx_end) ? '0 : tx_cnt + 17'd1;
      if (tx_pop) begin
        tx_sh  <= tx_rdata;
        tx_par <= ^tx_rdata ^ ctrl[3];
        tx_bit <= '0;
      end else if (tx_state == S_DATA && tx_end) begin
        tx_sh  <= {1'b0, tx_sh[7:1]};
        tx_bit <= tx_bit + 3'd1;
      end
    end

  // Decoded from state flops so reset forces the line idle immediately
  always_comb begin
    TxD = 1'b1;
    case (tx_state)
      S_START:  TxD = 1'b0;
      S_DATA:   TxD = tx_sh[0];
      S_PARITY: TxD = tx_par;
      default:  TxD = 1'b1;
    endcase
  end

  // Receiver
  logic [1:0]  rx_sync;
  logic        rx, rx_prev, rx_parbit, rx_mid, rx_end, rx_done;
  state_t      rx_state, rx_next;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic        ferr_set, perr_set, brk_set, ovr_set;

  assign rx     = rx_sync[1];
  assign rx_mid = (rx_cnt == half - 16'd1);
  assign rx_end = (rx_cnt == cpb_eff - 16'd1);

  always_comb begin
    rx_next = rx_state;
    rx_done = 1'b0;
    case (rx_state)
      S_IDLE:   if (ctrl[0] && rx_prev && !rx) rx_next = S_START;
      S_START:  if (rx_mid && rx) rx_next = S_IDLE;
                else if (rx_end) rx_next = S_DATA;
      S_DATA:   if (rx_end && rx_bit == 3'd7) rx_next = ctrl[2] ? S_PARITY : S_STOP;
      S_PARITY: if (rx_end) rx_next = S_STOP;
      S_STOP:   if (rx_mid) begin rx_next = S_IDLE; rx_done = 1'b1; end
      default:  rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      rx_sync   <= 2'b11;
      rx_prev   <= 1'b1;
      rx_state  <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_parbit <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], RxD};
      rx_prev  <= rx;
      rx_state <= rx_next;
      rx_cnt   <= (rx_state == S_IDLE || rx_end) ? '0 : rx_cnt + 16'd1;
      if (rx_state == S_IDLE) rx_bit <= '0;
      if (rx_state == S_DATA) begin
        if (rx_mid) rx_sh  <= {rx, rx_sh[7:1]};
        if (rx_end) rx_bit <= rx_bit + 3'd1;
      end
      if (rx_state == S_PARITY && rx_mid) rx_parbit <= rx;
    end

  // Evaluated at mid-stop, while rx holds the stop sample
  assign ferr_set = rx_done && !rx;
  assign perr_set = rx_done && ctrl[2] && (rx_parbit != (^rx_sh ^ ctrl[3]));
  assign brk_set  = rx_done && !rx && (rx_sh == 8'd0) && !(ctrl[2] && rx_parbit);
  assign rx_push  = rx_done && !brk_set && !rx_full;
  assign ovr_set  = rx_done && !brk_set && rx_full;

  // Registers, sticky flags, irq
  logic wr_rstat, wr_tstat, err_any;
  assign wr_rstat = wr & (addr == 4'd2);
  assign wr_tstat = wr & (addr == 4'd3);
  assign err_any  = (|rx_err) | tx_ovr;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ctrl    <= '0;
      cpb     <= 16'(CPB_RESET);
      ien     <= '0;
      rx_err  <= '0;
      tx_ovr  <= 1'b0;
      rd_prev <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr && addr == 4'd1) ctrl <= din[4:0];
      if (wr && addr == 4'd4) cpb  <= din[15:0];
      if (wr && addr == 4'd5) ien  <= din[2:0];
      rx_err  <= (rx_err & ~(wr_rstat ? din[5:2] : 4'b0))
               | {brk_set, ovr_set, perr_set, ferr_set};
      tx_ovr  <= (tx_ovr & ~(wr_tstat & din[3])) | (tx_push & tx_full);
      rd_prev <= rd_dr;
      irq     <= (~rx_empty & ien[0]) | (tc & ien[1]) | (err_any & ien[2]);
    end

  always_comb begin
    dout = '0;
    case (addr)
      4'd0: if (!rx_empty) dout[7:0] = rx_rdata;
      4'd1: dout[4:0]  = ctrl;
      4'd2: dout[15:0] = {8'(rx_count), 2'b00, rx_err, rx_full, ~rx_empty};
      4'd3: dout[15:0] = {8'(tx_count), 4'b0000, tx_ovr, tx_full, tx_empty, tc};
      4'd4: dout[15:0] = cpb;
      4'd5: dout[2:0]  = ien;
      default: dout = '0;
    endcase
  end
endmodule
